// File: rtl/pulse_stretching_device.sv
// Edge-triggered pulse stretcher: synchronises IN_PULSE, emits a fixed-length pulse, then a guard gap.
// Optional feature macro RETRIGGER_EN: a new edge while the pulse is high reloads the length counter.
module pulse_stretching_device #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic             IN_CLOCK,
    input  logic             IN_RESET_N,
    input  logic             IN_PULSE,
    input  logic [CNT_W-1:0] IN_LENGTH,
    output logic             OUT_LONG_PULSE,
    output logic             OUT_BUSY,
    output logic             OUT_MISSED
);

    localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic [ARM_W-1:0]       arm_r;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   missed_nxt_s;
    logic                   armed_s;
    logic                   edge_s;
    logic                   last_s;
    logic                   long_r;
    logic                   busy_r;
    logic                   missed_r;

    // Synchroniser, edge history and post-reset arming counter
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
            arm_r  <= {ARM_W{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], IN_PULSE};
            prev_r <= sync_r[SYNC_STAGES-1];
            if (arm_r != ARM_DONE) begin
                arm_r <= arm_r + {{(ARM_W-1){1'b0}}, 1'b1};
            end else begin
                arm_r <= arm_r;
            end
        end
    end

    // Arming masks the edge a level already high at release would otherwise produce
    assign armed_s = (arm_r == ARM_DONE);
    assign edge_s  = armed_s & sync_r[SYNC_STAGES-1] & ~prev_r;
    assign last_s  = (cnt_r <= CNT_ONE);

    // Next-state, counter and missed-trigger decode
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        missed_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (edge_s && (IN_LENGTH != CNT_ZERO)) begin
                    state_nxt_s = ST_ACTIVE;
                    cnt_nxt_s   = IN_LENGTH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
`ifdef RETRIGGER_EN
                if (edge_s && (IN_LENGTH != CNT_ZERO)) begin
                    cnt_nxt_s = IN_LENGTH;
                end else begin
                    missed_nxt_s = edge_s;
                    if (!last_s) begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_GAP;
                        cnt_nxt_s   = GAP_LOAD;
                    end
                end
`else
                missed_nxt_s = edge_s;
                if (!last_s) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else if (GAP_CYCLES == 0) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = GAP_LOAD;
                end
`endif
            end
            ST_GAP: begin
                missed_nxt_s = edge_s;
                if (last_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs (decoded from next state so they align with it)
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            long_r   <= 1'b0;
            busy_r   <= 1'b0;
            missed_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            long_r   <= (state_nxt_s == ST_ACTIVE);
            busy_r   <= (state_nxt_s != ST_IDLE);
            missed_r <= missed_nxt_s;
        end
    end

    assign OUT_LONG_PULSE = long_r;
    assign OUT_BUSY       = busy_r;
    assign OUT_MISSED     = missed_r;

endmodule
